// File: rtl/aq_gemac_mdio_pkg.sv
// aq_gemac_mdio_pkg: shared state encodings, opcodes and field widths for the Clause 22 MDIO responder.
package aq_gemac_mdio_pkg;
    typedef enum logic [2:0] {
        S_PREAMBLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST       = 2'b01;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction
endpackage

// File: rtl/aq_gemac_mdc_sync.sv
// aq_gemac_mdc_sync: 2-FF synchronizer for MDC/MDIO with single-cycle MDC rise/fall pulses.
module aq_gemac_mdc_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdio,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] r_mdc_sync;
    logic [1:0] r_mdio_sync;
    logic       r_mdc_dly;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mdc_sync  <= '0;
            r_mdio_sync <= '0;
            r_mdc_dly   <= 1'b0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[0], i_mdio};
            r_mdc_dly   <= r_mdc_sync[1];
        end
    end
    assign o_mdio = r_mdio_sync[1];
    assign o_rise = r_mdc_sync[1] & ~r_mdc_dly;
    assign o_fall = ~r_mdc_sync[1] & r_mdc_dly;
endmodule

// File: rtl/aq_gemac_mdio_slave.sv
// aq_gemac_mdio_slave: Clause 22 MDIO responder driving a 32x16 register strobe port.
// Optional preamble suppression: define AQ_GEMAC_MDIO_PRE_SUPPRESS_EN.
module aq_gemac_mdio_slave
    import aq_gemac_mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter logic [5:0] PRE_LEN  = 6'd32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mdc,
    input  logic        i_mdio_in,
    output logic        o_mdio_out,
    output logic        o_mdio_out_enable,
    output logic [4:0]  o_reg_addr,
    output logic [15:0] o_reg_wdata,
    output logic        o_reg_we,
    output logic        o_reg_re,
    input  logic [15:0] i_reg_rdata,
    output logic        o_frame_err
);
    logic        w_bit;
    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_shift_nxt;
    logic [5:0]  w_pre_req;
    state_t      r_state;
    logic [5:0]  r_pcnt;
    logic [3:0]  r_bcnt;
    logic [15:0] r_shift;
    logic        r_op_rd;
    logic        r_match;
    logic        r_rd_act;
    logic [4:0]  r_fcnt;
    logic [15:0] r_tx;
    logic        r_re_d;
    logic        r_mdio_out;
    logic        r_mdio_oe;
    logic [4:0]  r_reg_addr;
    logic [15:0] r_reg_wdata;
    logic        r_reg_we;
    logic        r_reg_re;
    logic        r_frame_err;

    aq_gemac_mdc_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_mdc   (i_mdc),
        .i_mdio  (i_mdio_in),
        .o_mdio  (w_bit),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_shift_nxt = {r_shift[14:0], w_bit};

`ifdef AQ_GEMAC_MDIO_PRE_SUPPRESS_EN
    logic r_sup;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_sup <= 1'b0;
        else if (r_frame_err)
            r_sup <= 1'b0;
        else if (w_rise && r_state == S_DATA && r_bcnt == 4'(DATA_W - 1) && r_match)
            r_sup <= 1'b1;
    end
    assign w_pre_req = r_sup ? 6'd1 : PRE_LEN;
`else
    assign w_pre_req = PRE_LEN;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_PREAMBLE;
            r_pcnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_op_rd     <= 1'b0;
            r_match     <= 1'b0;
            r_rd_act    <= 1'b0;
            r_fcnt      <= '0;
            r_tx        <= '0;
            r_re_d      <= 1'b0;
            r_mdio_out  <= 1'b0;
            r_mdio_oe   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
            r_re_d      <= r_reg_re;
            if (r_re_d)
                r_tx <= i_reg_rdata;
            if (w_rise) begin
                r_shift <= w_shift_nxt;
                r_bcnt  <= r_bcnt + 4'd1;
                unique case (r_state)
                    S_PREAMBLE: begin
                        r_bcnt <= '0;
                        if (w_bit)
                            r_pcnt <= (r_pcnt < PRE_LEN) ? r_pcnt + 6'd1 : r_pcnt;
                        else if (r_pcnt >= w_pre_req) begin
                            r_state <= S_ST;
                            r_pcnt  <= '0;
                        end else
                            r_pcnt <= '0;
                    end
                    S_ST: begin
                        r_bcnt      <= '0;
                        r_state     <= w_bit ? S_OP : S_PREAMBLE;
                        r_frame_err <= ~w_bit;
                    end
                    S_OP: if (r_bcnt == 4'd1) begin
                        r_bcnt      <= '0;
                        r_op_rd     <= w_shift_nxt[1:0] == OP_READ;
                        r_state     <= op_valid(w_shift_nxt[1:0]) ? S_PHYAD : S_PREAMBLE;
                        r_frame_err <= ~op_valid(w_shift_nxt[1:0]);
                    end
                    S_PHYAD: if (r_bcnt == 4'(PHYAD_W - 1)) begin
                        r_bcnt  <= '0;
                        r_match <= w_shift_nxt[4:0] == PHY_ADDR;
                        r_state <= S_REGAD;
                    end
                    S_REGAD: if (r_bcnt == 4'(REGAD_W - 1)) begin
                        r_bcnt  <= '0;
                        r_state <= S_TA;
                        if (r_match) begin
                            r_reg_addr <= w_shift_nxt[4:0];
                            if (r_op_rd) begin
                                r_reg_re <= 1'b1;
                                r_rd_act <= 1'b1;
                                r_fcnt   <= '0;
                            end
                        end
                    end
                    S_TA: if (r_bcnt == 4'd1) begin
                        r_bcnt  <= '0;
                        r_state <= S_DATA;
                    end
                    S_DATA: if (r_bcnt == 4'(DATA_W - 1)) begin
                        r_bcnt  <= '0;
                        r_pcnt  <= '0;
                        r_state <= S_PREAMBLE;
                        if (r_match && !r_op_rd) begin
                            r_reg_we    <= 1'b1;
                            r_reg_wdata <= w_shift_nxt;
                        end
                    end
                    default: r_state <= S_PREAMBLE;
                endcase
            end
            // Fall count 0 is the TA1 high-Z slot, 1 drives TA2 low, 2..17 carry data, 18 releases.
            if (w_fall && r_rd_act) begin
                r_fcnt <= r_fcnt + 5'd1;
                if (r_fcnt == 5'd1) begin
                    r_mdio_oe  <= 1'b1;
                    r_mdio_out <= 1'b0;
                end else if (r_fcnt >= 5'd2 && r_fcnt <= 5'd17) begin
                    r_mdio_out <= r_tx[15];
                    r_tx       <= {r_tx[14:0], 1'b0};
                end else if (r_fcnt == 5'd18) begin
                    r_mdio_oe  <= 1'b0;
                    r_mdio_out <= 1'b0;
                    r_rd_act   <= 1'b0;
                end
            end
        end
    end

    assign o_mdio_out        = r_mdio_out;
    assign o_mdio_out_enable = r_mdio_oe;
    assign o_reg_addr        = r_reg_addr;
    assign o_reg_wdata       = r_reg_wdata;
    assign o_reg_we          = r_reg_we;
    assign o_reg_re          = r_reg_re;
    assign o_frame_err       = r_frame_err;
endmodule

// File: tb/tb_aq_gemac_mdio_slave.sv
// tb_aq_gemac_mdio_slave: table-driven MDIO frames with a strobe scoreboard plus reset/preamble corner sequences.
module tb_aq_gemac_mdio_slave;
    import aq_gemac_mdio_pkg::*;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] data;
        logic        want_we;
        logic        want_re;
        int          want_err;
    } vec_t;

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio = 1'b1;
    logic [15:0] rdata = '0;
    logic        mdio_out;
    logic        oe;
    logic [4:0]  raddr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic        ferr;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_ferr = 0;
    int   n_oe_bad = 0;
    logic oe_allowed = 1'b0;
    sb_t  sb_q[$];
    vec_t vecs[10];

    aq_gemac_mdio_slave dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_mdc             (mdc),
        .i_mdio_in         (mdio),
        .o_mdio_out        (mdio_out),
        .o_mdio_out_enable (oe),
        .o_reg_addr        (raddr),
        .o_reg_wdata       (wdata),
        .o_reg_we          (we),
        .o_reg_re          (re),
        .i_reg_rdata       (rdata),
        .o_frame_err       (ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Scoreboard: every strobe pops the oldest expected access.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) n_ferr++;
            if (oe && !oe_allowed) n_oe_bad++;
            if (we || re) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe_unexpected: got we=%b re=%b addr=%0d expected none", we, re, raddr);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (we !== e.is_wr || re !== !e.is_wr || raddr !== e.addr || (e.is_wr && wdata !== e.data)) begin
                        n_err++;
                        $display("FAIL strobe: got we=%b re=%b addr=%0d wdata=%h expected wr=%b addr=%0d wdata=%h",
                                 we, re, raddr, wdata, e.is_wr, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic mdc_bit(input logic b, output logic s_oe, output logic s_out);
        mdc  = 1'b0;
        mdio = b;
        repeat (6) @(negedge clk);
        s_oe  = oe;
        s_out = mdio_out;
        mdc   = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] val, input int n);
        logic a, b;
        for (int i = n - 1; i >= 0; i--) mdc_bit(val[i], a, b);
    endtask

    task automatic send_hdr(input vec_t v, input int pre_n);
        send_bits(16'hFFFF, 0);
        for (int i = 0; i < pre_n; i++) send_bits(16'h1, 1);
        send_bits({14'b0, v.st}, 2);
        send_bits({14'b0, v.op}, 2);
        send_bits({11'b0, v.phy}, 5);
        send_bits({11'b0, v.regad}, 5);
    endtask

    task automatic run_frame(input string name, input vec_t v, input int pre_n);
        logic        s_oe, s_out, all_oe;
        logic [15:0] got;
        int          ferr0;
        sb_t         e;
        ferr0    = n_ferr;
        n_oe_bad = 0;
        rdata    = v.data;
        if (v.want_we || v.want_re) begin
            e.is_wr = v.want_we;
            e.addr  = v.regad;
            e.data  = v.data;
            sb_q.push_back(e);
        end
        send_hdr(v, pre_n);
        oe_allowed = v.want_re;
        for (int i = 0; i < 2; i++) begin
            mdc_bit((v.op == OP_READ) ? 1'b1 : (i == 0), s_oe, s_out);
            if (v.want_re && i == 0) chk({name, " ta1_oe"}, {31'b0, s_oe}, 32'd0);
            if (v.want_re && i == 1) chk({name, " ta2_oe_out"}, {30'b0, s_oe, s_out}, 32'd2);
        end
        all_oe = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            mdc_bit((v.op == OP_READ) ? 1'b1 : v.data[i], s_oe, s_out);
            got[i] = s_out;
            all_oe &= s_oe;
        end
        if (v.want_re) begin
            chk({name, " rd_data"}, {16'b0, got}, {16'b0, v.data});
            chk({name, " rd_oe"}, {31'b0, all_oe}, 32'd1);
        end
        mdc_bit(1'b1, s_oe, s_out);
        if (v.want_re) chk({name, " oe_release"}, {31'b0, s_oe}, 32'd0);
        oe_allowed = 1'b0;
        repeat (4) @(negedge clk);
        chk({name, " oe_stray"}, n_oe_bad, 0);
        chk({name, " frame_err"}, n_ferr - ferr0, v.want_err);
        chk({name, " strobe_missing"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        vec_t        v;
        logic        a, b;
        vecs[0] = '{ST,    OP_WRITE, 5'd1, 5'd5,  16'hA5C3, 1'b1, 1'b0, 0};
        vecs[1] = '{ST,    OP_READ,  5'd1, 5'd2,  16'h1234, 1'b0, 1'b1, 0};
        vecs[2] = '{ST,    OP_READ,  5'd3, 5'd2,  16'h1234, 1'b0, 1'b0, 0};
        vecs[3] = '{ST,    OP_WRITE, 5'd3, 5'd5,  16'hFFFF, 1'b0, 1'b0, 0};
        vecs[4] = '{ST,    OP_WRITE, 5'd1, 5'd31, 16'hFFFF, 1'b1, 1'b0, 0};
        vecs[5] = '{2'b00, OP_WRITE, 5'd1, 5'd5,  16'h0F0F, 1'b0, 1'b0, 1};
        vecs[6] = '{ST,    OP_READ,  5'd1, 5'd0,  16'h8001, 1'b0, 1'b1, 0};
        vecs[7] = '{ST,    2'b11,    5'd1, 5'd4,  16'h0000, 1'b0, 1'b0, 1};
        vecs[8] = '{ST,    2'b00,    5'd1, 5'd4,  16'h0000, 1'b0, 1'b0, 1};
        vecs[9] = '{ST,    OP_WRITE, 5'd1, 5'd0,  16'h0000, 1'b1, 1'b0, 0};

        repeat (4) @(negedge clk);
        chk("rst oe", {31'b0, oe}, 32'd0);
        chk("rst out", {31'b0, mdio_out}, 32'd0);
        chk("rst we_re", {30'b0, we, re}, 32'd0);
        chk("rst ferr", {31'b0, ferr}, 32'd0);
        chk("rst addr", {27'b0, raddr}, 32'd0);
        chk("rst wdata", {16'b0, wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), vecs[i], 32);

        // Short preamble after a completed frame for this PHY.
        run_frame("pre_good", vecs[0], 32);
        v = '{ST, OP_READ, 5'd1, 5'd7, 16'hBEEF, 1'b0, 1'b0, 0};
`ifdef AQ_GEMAC_MDIO_PRE_SUPPRESS_EN
        v.want_re = 1'b1;
`endif
        run_frame("pre_short", v, 20);
        run_frame("pre_recover", vecs[1], 32);

        // Reset asserted while read data bit 7 is on the wire.
        v = '{ST, OP_READ, 5'd1, 5'd2, 16'h5A5A, 1'b0, 1'b1, 0};
        rdata = v.data;
        sb_q.push_back('{1'b0, 5'd2, 16'h0});
        n_oe_bad = 0;
        send_hdr(v, 32);
        oe_allowed = 1'b1;
        for (int i = 0; i < 11; i++) mdc_bit(1'b1, a, b);
        chk("rstmid oe_before", {31'b0, oe}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid oe", {31'b0, oe}, 32'd0);
        chk("rstmid strobes", {30'b0, we, re}, 32'd0);
        oe_allowed = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) mdc_bit(1'b1, a, b);
        chk("rstmid oe_stray", n_oe_bad, 0);
        chk("rstmid strobe_missing", sb_q.size(), 0);
        run_frame("rstmid_write", vecs[0], 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
